// File: rtl/led_chaser_ctrl.sv
// Purpose : 8-LED chaser sequencer; a prescaled step generator moves a 3-bit
//           position (hold / up-wrap / down-wrap / ping-pong) that is decoded
//           onto an 8-bit LED bank.
// Latency : pos/dir/tick are registered (they change on the step edge); led is
//           combinational from pos, so it changes in the same cycle as pos.
// Flow    : no backpressure; enable=0 freezes all state, load overrides
//           stepping, rst overrides everything.
//
// Ports:
//   clk       system clock, all state updates on the rising edge
//   rst       synchronous active-high reset
//   enable    1 = prescaler and stepping run, 0 = freeze pos/dir/div_cnt
//   mode      00 hold, 01 up-wrap, 10 down-wrap, 11 ping-pong
//   speed     step period is speed+1 enabled cycles
//   load      synchronous load of load_pos (beats enable, loses to rst)
//   load_pos  position written on load
//   pos       current LED index
//   dir       current direction, 0 up, 1 down
//   tick      one-cycle pulse in the cycle after each step edge
//   led       decoded LED bank, only bit pos is active
module led_chaser_ctrl #(
  parameter int SPEED_W    = 3,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [1:0]         mode,
  input  logic [SPEED_W-1:0] speed,
  input  logic               load,
  input  logic [2:0]         load_pos,
  output logic [2:0]         pos,
  output logic               dir,
  output logic               tick,
  output logic [7:0]         led
);

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_UP   = 2'b01,
    MODE_DOWN = 2'b10,
    MODE_PING = 2'b11
  } mode_e;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  localparam logic [2:0] POS_MIN = 3'd0;
  localparam logic [2:0] POS_MAX = 3'd7;

  // State registers
  logic [2:0]         pos_q,     pos_d;
  logic               dir_q,     dir_d;
  logic [SPEED_W-1:0] div_cnt_q, div_cnt_d;
  logic               tick_q,    tick_d;

  // Prescaler / step decode
  logic  step_edge;
  mode_e mode_sel;

  assign mode_sel = mode_e'(mode);

  // ">=" rather than "==" so that lowering speed below the current count
  // produces a step on the next edge instead of a long wrap through the
  // whole counter range.
  assign step_edge = enable && (div_cnt_q >= speed);

  // Next-position logic used only on a step edge
  logic [2:0] step_pos;
  logic       step_dir;

  always_comb begin
    step_pos = pos_q;
    step_dir = dir_q;
    unique case (mode_sel)
      MODE_HOLD: begin
        step_pos = pos_q;
        step_dir = dir_q;
      end
      MODE_UP: begin
        step_pos = pos_q + 3'd1;   // natural 3-bit wrap 7 -> 0
        step_dir = DIR_UP;
      end
      MODE_DOWN: begin
        step_pos = pos_q - 3'd1;   // natural 3-bit wrap 0 -> 7
        step_dir = DIR_DOWN;
      end
      MODE_PING: begin
        // Endpoints reverse immediately so the end LED is lit for one step
        // only (0,1,..,7,6,..,0,1,..). The stored dir is honoured, so
        // switching into ping-pong continues the previous direction.
        if (dir_q == DIR_UP) begin
          if (pos_q == POS_MAX) begin
            step_pos = POS_MAX - 3'd1;
            step_dir = DIR_DOWN;
          end else begin
            step_pos = pos_q + 3'd1;
          end
        end else begin
          if (pos_q == POS_MIN) begin
            step_pos = POS_MIN + 3'd1;
            step_dir = DIR_UP;
          end else begin
            step_pos = pos_q - 3'd1;
          end
        end
      end
      default: begin
        step_pos = pos_q;
        step_dir = dir_q;
      end
    endcase
  end

  // Next-state logic: load > enable stepping > hold
  always_comb begin
    pos_d     = pos_q;
    dir_d     = dir_q;
    div_cnt_d = div_cnt_q;
    tick_d    = 1'b0;

    if (load) begin
      // dir is deliberately kept so a loaded ping-pong carries on its way
      pos_d     = load_pos;
      div_cnt_d = '0;
    end else if (enable) begin
      if (step_edge) begin
        div_cnt_d = '0;
        tick_d    = 1'b1;
        pos_d     = step_pos;
        dir_d     = step_dir;
      end else begin
        div_cnt_d = div_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pos_q     <= POS_MIN;
      dir_q     <= DIR_UP;
      div_cnt_q <= '0;
      tick_q    <= 1'b0;
    end else begin
      pos_q     <= pos_d;
      dir_q     <= dir_d;
      div_cnt_q <= div_cnt_d;
      tick_q    <= tick_d;
    end
  end

  // One-hot LED decode, straight from the registered position
  logic [7:0] led_onehot;

  always_comb begin
    led_onehot = 8'd0;
    led_onehot[pos_q] = 1'b1;
  end

  assign led  = ACTIVE_LOW ? ~led_onehot : led_onehot;
  assign pos  = pos_q;
  assign dir  = dir_q;
  assign tick = tick_q;

endmodule

// File: tb/tb_led_chaser_ctrl.sv
// Testbench for led_chaser_ctrl: directed vector table, hand-written corner
// sequences and randomized stimulus against a behavioural model. A second
// instance with ACTIVE_LOW=0 shares the inputs to cover the other polarity.
module tb_led_chaser_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [2:0] speed = 3'd0;
  logic       load = 1'b0;
  logic [2:0] load_pos = 3'd0;

  logic [2:0] pos,  pos2;
  logic       dir,  dir2;
  logic       tick, tick2;
  logic [7:0] led,  led2;

  led_chaser_ctrl #(.SPEED_W(3), .ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode), .speed(speed),
    .load(load), .load_pos(load_pos),
    .pos(pos), .dir(dir), .tick(tick), .led(led)
  );

  led_chaser_ctrl #(.SPEED_W(3), .ACTIVE_LOW(1'b0)) dut_hi (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode), .speed(speed),
    .load(load), .load_pos(load_pos),
    .pos(pos2), .dir(dir2), .tick(tick2), .led(led2)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %02h expected %02h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_pos = 0, m_dir = 0, m_cnt = 0, m_tick = 0;

  // Ping-pong is viewed as a walk around a 14-step ring of phases:
  // phase p shows LED p for p<=7 and LED 14-p otherwise. dir is simply
  // whether the last move went downwards.
  task automatic model_step(input logic r, input logic ld, input logic [2:0] lp,
                            input logic en, input logic [1:0] md, input logic [2:0] sp);
    int ph, np;
    if (r) begin
      m_pos = 0; m_dir = 0; m_cnt = 0; m_tick = 0;
    end else if (ld) begin
      m_pos = int'(lp); m_cnt = 0; m_tick = 0;
    end else if (!en) begin
      m_tick = 0;
    end else if (m_cnt >= int'(sp)) begin
      m_cnt = 0; m_tick = 1;
      case (md)
        2'd1: begin m_pos = (m_pos + 1) % 8; m_dir = 0; end
        2'd2: begin m_pos = (m_pos + 7) % 8; m_dir = 1; end
        2'd3: begin
          ph = (m_dir == 1) ? (14 - m_pos) % 14 : m_pos;
          ph = (ph + 1) % 14;
          np = (ph <= 7) ? ph : 14 - ph;
          m_dir = (np < m_pos) ? 1 : 0;
          m_pos = np;
        end
        default: ;
      endcase
    end else begin
      m_cnt++; m_tick = 0;
    end
  endtask

  function automatic logic [7:0] bank(input int p, input bit act_low);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[i] = (i == p) ? !act_low : act_low;
    return b;
  endfunction

  task automatic check_model(input string tag);
    chk({tag, ".pos"},  8'(pos),   8'(m_pos));
    chk({tag, ".dir"},  8'(dir),   8'(m_dir));
    chk({tag, ".tick"}, 8'(tick),  8'(m_tick));
    chk({tag, ".led"},  led,       bank(m_pos, 1'b1));
    chk({tag, ".led_al0"}, led2,   bank(m_pos, 1'b0));
    chk({tag, ".pos_al0"}, 8'(pos2), 8'(m_pos));
  endtask

  // Apply inputs, take one rising edge, advance the model, sample 1ns later.
  task automatic do_cycle(input logic r, input logic ld, input logic [2:0] lp,
                          input logic en, input logic [1:0] md, input logic [2:0] sp);
    rst = r; load = ld; load_pos = lp; enable = en; mode = md; speed = sp;
    @(posedge clk);
    model_step(r, ld, lp, en, md, sp);
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic       r, ld;
    logic [2:0] lp;
    logic       en;
    logic [1:0] md;
    logic [2:0] sp;
    logic [2:0] e_pos;
    logic       e_dir, e_tick;
    logic [7:0] e_led;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic r, input logic ld, input logic [2:0] lp, input logic en,
                     input logic [1:0] md, input logic [2:0] sp, input logic [2:0] e_pos,
                     input logic e_dir, input logic e_tick, input logic [7:0] e_led);
    vec_t v;
    v.r = r; v.ld = ld; v.lp = lp; v.en = en; v.md = md; v.sp = sp;
    v.e_pos = e_pos; v.e_dir = e_dir; v.e_tick = e_tick; v.e_led = e_led;
    vt.push_back(v);
  endtask

  initial begin
    // reset state
    add(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 8'hFE);
    // up-wrap, speed 0: step every cycle, tick held high
    add(0, 0, 0, 1, 2'b01, 0, 1, 0, 1, 8'hFD);
    add(0, 0, 0, 1, 2'b01, 0, 2, 0, 1, 8'hFB);
    add(0, 0, 0, 1, 2'b01, 0, 3, 0, 1, 8'hF7);
    add(0, 0, 0, 1, 2'b01, 0, 4, 0, 1, 8'hEF);
    add(0, 0, 0, 1, 2'b01, 0, 5, 0, 1, 8'hDF);
    add(0, 0, 0, 1, 2'b01, 0, 6, 0, 1, 8'hBF);
    add(0, 0, 0, 1, 2'b01, 0, 7, 0, 1, 8'h7F);
    add(0, 0, 0, 1, 2'b01, 0, 0, 0, 1, 8'hFE);
    add(0, 0, 0, 1, 2'b01, 0, 1, 0, 1, 8'hFD);
    add(0, 0, 0, 1, 2'b01, 0, 2, 0, 1, 8'hFB);
    // reset, then down-wrap speed 2: steps at edges 3, 6, 9
    add(1, 0, 0, 1, 2'b10, 2, 0, 0, 0, 8'hFE);
    add(0, 0, 0, 1, 2'b10, 2, 0, 0, 0, 8'hFE);
    add(0, 0, 0, 1, 2'b10, 2, 0, 0, 0, 8'hFE);
    add(0, 0, 0, 1, 2'b10, 2, 7, 1, 1, 8'h7F);
    add(0, 0, 0, 1, 2'b10, 2, 7, 1, 0, 8'h7F);
    add(0, 0, 0, 1, 2'b10, 2, 7, 1, 0, 8'h7F);
    add(0, 0, 0, 1, 2'b10, 2, 6, 1, 1, 8'hBF);
    add(0, 0, 0, 1, 2'b10, 2, 6, 1, 0, 8'hBF);
    add(0, 0, 0, 1, 2'b10, 2, 6, 1, 0, 8'hBF);
    add(0, 0, 0, 1, 2'b10, 2, 5, 1, 1, 8'hDF);
    // load on what would be a step edge: load wins, tick low, dir kept
    add(0, 1, 5, 1, 2'b01, 0, 5, 1, 0, 8'hDF);
    // reset beats load
    add(1, 1, 3, 1, 2'b01, 0, 0, 0, 0, 8'hFE);

    for (int i = 0; i < vt.size(); i++) begin
      do_cycle(vt[i].r, vt[i].ld, vt[i].lp, vt[i].en, vt[i].md, vt[i].sp);
      chk($sformatf("vec%0d.pos", i),  8'(pos),  8'(vt[i].e_pos));
      chk($sformatf("vec%0d.dir", i),  8'(dir),  8'(vt[i].e_dir));
      chk($sformatf("vec%0d.tick", i), 8'(tick), 8'(vt[i].e_tick));
      chk($sformatf("vec%0d.led", i),  led,      vt[i].e_led);
    end

    // ---------------- ping-pong endpoints ----------------
    do_cycle(0, 1, 6, 0, 2'b11, 0);              // pos=6, dir=0
    do_cycle(0, 0, 0, 1, 2'b11, 0); check_model("pp_a1");
    chk("pp_a1.pos", 8'(pos), 8'd7); chk("pp_a1.dir", 8'(dir), 8'd0);
    do_cycle(0, 0, 0, 1, 2'b11, 0); check_model("pp_a2");
    chk("pp_a2.pos", 8'(pos), 8'd6); chk("pp_a2.dir", 8'(dir), 8'd1);
    do_cycle(0, 0, 0, 1, 2'b11, 0); check_model("pp_a3");
    chk("pp_a3.pos", 8'(pos), 8'd5);
    do_cycle(0, 1, 1, 0, 2'b11, 0);              // pos=1, dir stays 1
    do_cycle(0, 0, 0, 1, 2'b11, 0);
    chk("pp_b1.pos", 8'(pos), 8'd0); chk("pp_b1.dir", 8'(dir), 8'd1);
    do_cycle(0, 0, 0, 1, 2'b11, 0);
    chk("pp_b2.pos", 8'(pos), 8'd1); chk("pp_b2.dir", 8'(dir), 8'd0);
    do_cycle(0, 0, 0, 1, 2'b11, 0);
    chk("pp_b3.pos", 8'(pos), 8'd2); check_model("pp_b3");

    // ---------------- freeze mid-count ----------------
    do_cycle(0, 1, 4, 1, 2'b01, 3);              // pos=4, count=0
    do_cycle(0, 0, 0, 1, 2'b01, 3);              // count 1
    do_cycle(0, 0, 0, 1, 2'b01, 3);              // count 2
    for (int i = 0; i < 5; i++) begin
      do_cycle(0, 0, 0, 0, 2'b01, 3);
      chk($sformatf("frz%0d.pos", i),  8'(pos),  8'd4);
      chk($sformatf("frz%0d.tick", i), 8'(tick), 8'd0);
      chk($sformatf("frz%0d.led", i),  led,      8'hEF);
    end
    do_cycle(0, 0, 0, 1, 2'b01, 3);
    chk("frz_re1.pos", 8'(pos), 8'd4); chk("frz_re1.tick", 8'(tick), 8'd0);
    do_cycle(0, 0, 0, 1, 2'b01, 3);
    chk("frz_re2.pos", 8'(pos), 8'd5); chk("frz_re2.tick", 8'(tick), 8'd1);

    // ---------------- speed drop mid-count ----------------
    do_cycle(0, 1, 0, 1, 2'b01, 7);
    for (int i = 0; i < 5; i++) do_cycle(0, 0, 0, 1, 2'b01, 7);   // count 5
    chk("spd_pre.pos", 8'(pos), 8'd0);
    do_cycle(0, 0, 0, 1, 2'b01, 1);
    chk("spd_s1.pos", 8'(pos), 8'd1); chk("spd_s1.tick", 8'(tick), 8'd1);
    do_cycle(0, 0, 0, 1, 2'b01, 1);
    chk("spd_s2.pos", 8'(pos), 8'd1); chk("spd_s2.tick", 8'(tick), 8'd0);
    do_cycle(0, 0, 0, 1, 2'b01, 1);
    chk("spd_s3.pos", 8'(pos), 8'd2); chk("spd_s3.tick", 8'(tick), 8'd1);

    // ---------------- hold mode still ticks; other polarity ----------------
    do_cycle(0, 1, 3, 1, 2'b00, 0);
    chk("al0.led", led2, 8'h08);
    do_cycle(0, 0, 0, 1, 2'b00, 0);
    chk("hold.pos", 8'(pos), 8'd3); chk("hold.tick", 8'(tick), 8'd1);

    // ---------------- randomized ----------------
    begin
      logic [1:0] md;
      logic [2:0] sp;
      md = 2'b01; sp = 3'd0;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 19) == 0) md = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 29) == 0) sp = 3'($urandom_range(0, 7));
        do_cycle($urandom_range(0, 199) == 0,
                 $urandom_range(0, 39) == 0,
                 3'($urandom_range(0, 7)),
                 $urandom_range(0, 7) != 0,
                 md, sp);
        check_model($sformatf("rnd%0d", i));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/led_chaser_ctrl.md
Name: led_chaser_ctrl

Overview:
- Sequencer that drives the 8-LED one-hot decoder datapath: a prescaled step generator moves a 3-bit LED position each step, and the position is decoded onto the LED bank.
- Supports hold, up-wrap, down-wrap and ping-pong patterns.
- Supports a synchronous position load for a board switch.
- Sits between the board switches/enable and the LED outputs.

Parameters:
- SPEED_W, 3, width of the speed input and the prescaler counter.
- ACTIVE_LOW, 1, LED polarity. 1: lit LED = 0 (idle bank 8'hFF). 0: lit LED = 1.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- enable  input  1  1 = prescaler and stepping run. 0 = freeze all state.
- mode  input  2  00 hold, 01 up-wrap, 10 down-wrap, 11 ping-pong.
- speed  input  SPEED_W  step period = speed+1 clock cycles.
- load  input  1  synchronous load of load_pos. Highest priority after rst.
- load_pos  input  3  position written on load.
- pos  output  3  current LED index (registered).
- dir  output  1  current direction: 0 up, 1 down (registered).
- tick  output  1  one-cycle pulse, registered, high in the cycle after a step edge.
- led  output  8  decoded LED bank: bit pos active, all others inactive.

Behaviour:
- Reset (rst=1 at edge): pos=0, dir=0, div_cnt=0, tick=0. led=8'hFE (ACTIVE_LOW=1) or 8'h01 (ACTIVE_LOW=0).
- led is combinational from pos only, so it changes in the same cycle as pos. ACTIVE_LOW=1: led = ~(8'b1<<pos). ACTIVE_LOW=0: led = 8'b1<<pos.
- Priority per edge: rst > load > enable stepping.
- load=1: pos<=load_pos, div_cnt<=0, tick<=0, dir unchanged. This applies regardless of enable.
- enable=0 and no load: pos, dir and div_cnt hold; tick<=0.
- enable=1 prescaler:
  - If div_cnt >= speed: step edge, div_cnt<=0, tick<=1.
  - Otherwise div_cnt<=div_cnt+1, tick<=0.
  - The >= compare means a speed decrease mid-count steps on the next edge, with no long wrap.
  - speed=0 steps every cycle; tick is then held high continuously.
- On a step edge, by mode:
  - 00 hold: pos unchanged, dir unchanged. Prescaler and tick still run.
  - 01 up-wrap: pos<=pos+1 mod 8 (7->0). dir<=0.
  - 10 down-wrap: pos<=pos-1 mod 8 (0->7). dir<=1.
  - 11 ping-pong, using the stored dir:
    - dir=0, pos<7: pos+1.
    - dir=0, pos=7: pos<=6, dir<=1.
    - dir=1, pos>0: pos-1.
    - dir=1, pos=0: pos<=1, dir<=0.
    - The sequence from 0 is 0,1,...,7,6,...,0,1,... with no repeated endpoint.
- Mode changes take effect on the next step edge. Switching into 11 continues in the stored dir.
- Reset asserted mid-count discards the partial count. The first step after reset release occurs speed+1 enabled cycles later.
- tick is asserted exactly once per step edge, including mode 00. It is never asserted on a load or reset edge.

Test Plan:
- Reset then mode=01, speed=0, enable=1 for 10 cycles -> pos 1,2,...,7,0,1,2 on successive edges. led 8'hFD, 8'hFB, ..., 8'h7F, 8'hFE. tick=1 every cycle.
- mode=10, speed=2 from reset -> pos 7,6,5 at edges 3,6,9. tick high one cycle after each. div_cnt idle cycles give no led change.
- mode=11, speed=0 from pos=6 dir=0 -> pos 7,6,5 with dir going 0->1 at the 7->6 step. From pos=1 dir=1 -> 0,1,2 with dir 1->0.
- enable=0 for 5 cycles mid-count (speed=3, div_cnt=2) -> pos/led/dir frozen, tick=0. On re-enable the step occurs after exactly 2 more cycles.
- load=1, load_pos=5 concurrent with a step edge and enable=1 -> pos=5, led=8'hDF, tick=0, div_cnt restarts. rst=1 with load=1 -> pos=0, led=8'hFE.
- speed changed 7->1 while div_cnt=5 -> step on the very next edge, then period 2. ACTIVE_LOW=0 instance at pos=3 -> led=8'h08.
